// File: rtl/prec_mult_pipe_mac.sv
// prec_mult_pipe_mac
//   Pipelined precision-configurable multiplier/accumulator. It runs either one
//   WxW multiply (full mode) or two packed HxH lane multiplies (half mode,
//   H=(W-1)/2). Each operand has its own signedness. The result stream uses a
//   valid/ready handshake, and a lane-aware accumulator is updated as each beat
//   reaches the output register.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (combinational, low only while stalled)
//   A, B       operands; half mode: lane1=[W-1:H+1], lane0=[H-1:0], bit H ignored
//   A_sign     A (or each A lane) is two's complement
//   B_sign     B (or each B lane) is two's complement
//   HALF       0: one WxW product, 1: two HxH lane products
//   acc_en     1: accumulate this beat, 0: load ACC with its product
//   acc_clr    1: load ACC with this beat's product (overrides acc_en)
//   out_valid  P/ACC hold a valid result
//   out_ready  downstream accepts the result
//   P          product; half: lane1=P[2W-1:2H+2], lane0=P[2H-1:0], P[2H+1:2H]=0
//   ACC        accumulator; half: lane1=ACC[ACC_W-1:W+G], lane0=ACC[W+G-1:0]
module prec_mult_pipe_mac #(
  parameter int W       = 9,
  parameter int LATENCY = 2,
  parameter int G       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           A,
  input  logic [W-1:0]           B,
  input  logic                   A_sign,
  input  logic                   B_sign,
  input  logic                   HALF,
  input  logic                   acc_en,
  input  logic                   acc_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*W-1:0]         P,
  output logic [2*W+2*G-1:0]     ACC
);

  localparam int H     = (W - 1) / 2;
  localparam int ACC_W = 2 * W + 2 * G;
  localparam int LW    = W + G;

  // One beat as it travels down the pipe: product plus the control it needs
  // at the accumulator.
  typedef struct packed {
    logic           load;
    logic           sext;
    logic           half;
    logic [2*W-1:0] prod;
  } beat_t;

  // Operands are extended to the full result width before multiplying, so the
  // low 2W bits of the product are exact for any signedness mix.
  function automatic logic [2*W-1:0] mul_full(input logic [W-1:0] a, input logic as,
                                              input logic [W-1:0] b, input logic bs);
    logic signed [2*W-1:0] ae;
    logic signed [2*W-1:0] be;
    ae = $signed({{W{as & a[W-1]}}, a});
    be = $signed({{W{bs & b[W-1]}}, b});
    return ae * be;
  endfunction

  function automatic logic [2*H-1:0] mul_lane(input logic [H-1:0] a, input logic as,
                                              input logic [H-1:0] b, input logic bs);
    logic signed [2*H-1:0] ae;
    logic signed [2*H-1:0] be;
    ae = $signed({{H{as & a[H-1]}}, a});
    be = $signed({{H{bs & b[H-1]}}, b});
    return ae * be;
  endfunction

  function automatic logic [ACC_W-1:0] ext_full(input logic [2*W-1:0] p, input logic s);
    return {{(ACC_W-2*W){s & p[2*W-1]}}, p};
  endfunction

  function automatic logic [LW-1:0] ext_lane(input logic [2*H-1:0] p, input logic s);
    return {{(LW-2*H){s & p[2*H-1]}}, p};
  endfunction

  logic  advance;
  beat_t beat_p0;
  logic  vld_p0;
  beat_t beat_pl;
  logic  vld_pl;

  // A stall freezes every stage at once; bubbles are kept.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;
  assign vld_p0   = in_valid;

  // ---- stage 0: multiply (combinational, captured by stage 1) ----
  always_comb begin
    beat_p0.load = acc_clr | ~acc_en;
    beat_p0.sext = A_sign | B_sign;
    beat_p0.half = HALF;
    if (HALF) begin
      beat_p0.prod = {mul_lane(A[W-1:H+1], A_sign, B[W-1:H+1], B_sign),
                      2'b00,
                      mul_lane(A[H-1:0], A_sign, B[H-1:0], B_sign)};
    end else begin
      beat_p0.prod = mul_full(A, A_sign, B, B_sign);
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign beat_pl = beat_p0;
      assign vld_pl  = vld_p0;
    end else begin : g_pipe
      beat_t beat_p [1:LATENCY-1];
      logic  vld_p  [1:LATENCY-1];

      // ---- stages 1..LATENCY-1: product register then delay ----
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 1; k < LATENCY; k++) vld_p[k] <= 1'b0;
        end else if (advance) begin
          vld_p[1] <= vld_p0;
          for (int k = LATENCY - 1; k >= 2; k--) vld_p[k] <= vld_p[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          beat_p[1] <= beat_p0;
          for (int k = LATENCY - 1; k >= 2; k--) beat_p[k] <= beat_p[k-1];
        end
      end

      assign beat_pl = beat_p[LATENCY-1];
      assign vld_pl  = vld_p[LATENCY-1];
    end
  endgenerate

  // Mode history: a beat must reload ACC if it is the first since reset or if
  // it switches between full and half mode.
  logic             hist_vld;
  logic             prev_half;
  logic             load_now;
  logic [ACC_W-1:0] ext_f;
  logic [LW-1:0]    ext_1;
  logic [LW-1:0]    ext_0;
  logic [ACC_W-1:0] acc_next;

  always_comb begin
    load_now = beat_pl.load | ~hist_vld | (beat_pl.half != prev_half);
    ext_f    = ext_full(beat_pl.prod, beat_pl.sext);
    ext_1    = ext_lane(beat_pl.prod[2*W-1:2*H+2], beat_pl.sext);
    ext_0    = ext_lane(beat_pl.prod[2*H-1:0], beat_pl.sext);
    acc_next = ACC;
    if (beat_pl.half) begin
      // Lanes are summed separately so no carry crosses the lane boundary.
      acc_next[ACC_W-1:LW] = load_now ? ext_1 : ACC[ACC_W-1:LW] + ext_1;
      acc_next[LW-1:0]     = load_now ? ext_0 : ACC[LW-1:0] + ext_0;
    end else begin
      acc_next = load_now ? ext_f : ACC + ext_f;
    end
  end

  // ---- final stage: P / ACC output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      P         <= '0;
      ACC       <= '0;
      hist_vld  <= 1'b0;
      prev_half <= 1'b0;
    end else if (advance) begin
      out_valid <= vld_pl;
      if (vld_pl) begin
        P         <= beat_pl.prod;
        ACC       <= acc_next;
        hist_vld  <= 1'b1;
        prev_half <= beat_pl.half;
      end
    end
  end

endmodule

// File: tb/tb_prec_mult_pipe_mac.sv
module tb_prec_mult_pipe_mac;

  localparam int W       = 9;
  localparam int LATENCY = 2;
  localparam int G       = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          A_sign;
  logic          B_sign;
  logic          HALF;
  logic          acc_en;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [17:0]   P;
  logic [25:0]   ACC;

  prec_mult_pipe_mac #(.W(W), .LATENCY(LATENCY), .G(G)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .A_sign(A_sign), .B_sign(B_sign), .HALF(HALF),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .P(P), .ACC(ACC)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] p;
    logic [25:0] acc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [25:0] m_acc = '0;
  bit          m_hist = 1'b0;
  logic        m_half = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int full_val(input logic [8:0] x, input logic s);
    return (s && x[8]) ? int'(x) - 512 : int'(x);
  endfunction

  function automatic int lane_val(input logic [3:0] x, input logic s);
    return (s && x[3]) ? int'(x) - 16 : int'(x);
  endfunction

  task automatic model_reset();
    sb_q.delete();
    m_acc  = '0;
    m_hist = 1'b0;
    m_half = 1'b0;
  endtask

  // Reference: exact integer products; ACC adds the exact product value.
  task automatic model_push(input logic [8:0] a, input logic [8:0] b, input logic as,
                            input logic bs, input logic hf, input logic en, input logic clr);
    exp_t e;
    bit   load;
    int   pv;
    int   p1v;
    int   p0v;
    load = clr || !en || !m_hist || (hf != m_half);
    if (!hf) begin
      pv    = full_val(a, as) * full_val(b, bs);
      e.p   = pv[17:0];
      m_acc = load ? pv[25:0] : m_acc + pv[25:0];
    end else begin
      p1v   = lane_val(a[8:5], as) * lane_val(b[8:5], bs);
      p0v   = lane_val(a[3:0], as) * lane_val(b[3:0], bs);
      e.p   = {p1v[7:0], 2'b00, p0v[7:0]};
      m_acc = load ? {p1v[12:0], p0v[12:0]}
                   : {m_acc[25:13] + p1v[12:0], m_acc[12:0] + p0v[12:0]};
    end
    e.acc  = m_acc;
    m_hist = 1'b1;
    m_half = hf;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a beat (caller is just after a rising edge) and hold it until accepted.
  task automatic send(input logic [8:0] a, input logic [8:0] b, input logic as, input logic bs,
                      input logic hf, input logic en, input logic clr);
    bit ok;
    ok = 1'b0;
    A = a; B = b; A_sign = as; B_sign = bs; HALF = hf; acc_en = en; acc_clr = clr;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    assert (ok) else begin
      n_err++;
      $error("FAIL send_timeout: observed in_ready %b expected 1", in_ready);
    end
    if (ok) begin
      model_push(a, b, as, bs, hf, en, clr);
      step();
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    assert (seen) else begin
      n_err++;
      $error("FAIL %s: observed out_valid %b expected 1", tag, out_valid);
    end
  endtask

  // Scoreboard: every transferred result is popped and compared in order.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_vec++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed P %0h ACC %0h expected no output", P, ACC);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_p", 64'(P), 64'(e.p));
        check("sb_acc", 64'(ACC), 64'(e.acc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    A = 9'h1FF; B = 9'h1FF; A_sign = 1'b0; B_sign = 1'b0;
    HALF = 1'b0; acc_en = 1'b1; acc_clr = 1'b0;

    // Reset held 3 cycles with in_valid high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_p", 64'(P), 64'd0);
    check("rst_acc", 64'(ACC), 64'd0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_idle_valid", 64'(out_valid), 64'd0);

    // First beat latency and full unsigned product
    step();
    send(9'h1FF, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("lat_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_two", 64'(out_valid), 64'd1);
    check("p_full_uns", 64'(P), 64'h3FC01);
    check("acc_full_uns", 64'(ACC), 64'h3FC01);

    // Full mixed signed*unsigned
    step();
    send(9'h1FF, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    wait_out("wait_mixed");
    check("p_full_mixed", 64'(P), 64'h3FE01);
    check("acc_full_mixed", 64'(ACC), 64'h3FFFE01);

    // Half signed lanes (mode change reloads ACC)
    step();
    send(9'b1000_1_0111, 9'b1000_1_1001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();
    wait_out("wait_half");
    check("p_half_l1", 64'(P[17:10]), 64'h40);
    check("p_half_l0", 64'(P[7:0]), 64'hCF);
    check("p_half_gap", 64'(P[9:8]), 64'h0);
    check("acc_half", 64'(ACC), 64'h0081FCF);

    // Accumulate, full unsigned, back-to-back
    step();
    send(9'd3, 9'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send(9'd2, 9'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(9'd1, 9'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("acc_step2", 64'(ACC), 64'd29);
    @(negedge clk);
    check("acc_step3", 64'(ACC), 64'd30);
    step();
    send(9'd2, 9'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    wait_out("wait_reload");
    check("acc_mode_reload", 64'(ACC), 64'd4);
    check("p_half_small", 64'(P), 64'd4);

    // Backpressure: three beats while downstream stalls
    repeat (3) step();
    fork
      begin
        send(9'd10, 9'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(9'd20, 9'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(9'd7, 9'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
      end
      begin
        logic [17:0] hp;
        logic [25:0] ha;
        out_ready = 1'b0;
        wait_out("wait_bp");
        hp = P;
        ha = ACC;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready_hold", 64'(in_ready), 64'd0);
          check("bp_valid_hold", 64'(out_valid), 64'd1);
          check("bp_p_stable", 64'(P), 64'(hp));
          check("bp_acc_stable", 64'(ACC), 64'(ha));
        end
        step();
        out_ready = 1'b1;
      end
    join
    repeat (6) step();
    check("bp_acc_final", 64'(ACC), 64'd209);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Reset with beats in flight
    send(9'd5, 9'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    A = 9'd7; B = 9'd8; acc_clr = 1'b0; in_valid = 1'b1;
    rst_n = 1'b0;
    model_reset();
    step();
    @(negedge clk);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_p", 64'(P), 64'd0);
    check("mid_rst_acc", 64'(ACC), 64'd0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_dropped", 64'(out_valid), 64'd0);
    end
    step();
    send(9'd4, 9'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    wait_out("wait_post_rst");
    check("post_rst_load", 64'(ACC), 64'd16);

    repeat (5) step();
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
